// File: rtl/shift_reg_n.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | shift_reg_n : N-bit shift/rotate register with single-op and burst modes     |
// | Revision    : 1.0                                                            |
// +-----------------------------------------------------------------------------+
module shift_reg_n #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CW      = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROTL  = 3'b100;
  localparam logic [2:0] OP_ROTR  = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  localparam logic [CW-1:0] C_CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             done_q, done_d;

  logic [CW-1:0]    w_cnt_sat;
  logic             w_burst_op;

  function automatic logic [WIDTH-1:0] f_apply(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] res;
    case (op)
      OP_HOLD:  res = cur;
      OP_LOAD:  res = ld;
      OP_SHL:   res = {cur[WIDTH-2:0], sr};
      OP_SHR:   res = {sl, cur[WIDTH-1:1]};
      OP_ROTL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ROTR:  res = {cur[0], cur[WIDTH-1:1]};
      OP_ASR:   res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      OP_CLEAR: res = '0;
      default:  res = cur;
    endcase
    return res;
  endfunction

  assign w_cnt_sat  = (cnt > C_CNT_MAX) ? C_CNT_MAX : cnt;
  assign w_burst_op = (mode >= OP_SHL) && (mode <= OP_ASR);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    op_d    = op_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && w_burst_op) begin
          // First op of a burst lands on the accepting edge itself
          if (w_cnt_sat == '0) begin
            done_d = 1'b1;
          end else begin
            q_d  = f_apply(mode, q_q, d, sin_l, sin_r);
            op_d = mode;
            if (w_cnt_sat == C_CNT_ONE) begin
              rem_d  = '0;
              done_d = 1'b1;
            end else begin
              rem_d   = w_cnt_sat - C_CNT_ONE;
              state_d = BURST;
            end
          end
        end else if (en) begin
          q_d = f_apply(mode, q_q, d, sin_l, sin_r);
        end
      end
      BURST: begin
        q_d   = f_apply(op_q, q_q, d, sin_l, sin_r);
        rem_d = rem_q - C_CNT_ONE;
        if (rem_q == C_CNT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= RST_VAL;
      op_q    <= OP_HOLD;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = (state_q == BURST);
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_n.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_shift_reg_n : directed scoreboard bench for shift_reg_n (WIDTH=8)         |
// | Revision       : 1.0                                                         |
// +-----------------------------------------------------------------------------+
module tb_shift_reg_n;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH+1);

  logic             clk;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic             start;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  shift_reg_n #(.WIDTH(WIDTH), .RST_VAL(8'h00)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .start  (start),
    .cnt    (cnt),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input string            tag,
    input logic             i_rst,
    input logic             i_en,
    input logic [2:0]       i_mode,
    input logic [WIDTH-1:0] i_d,
    input logic             i_sl,
    input logic             i_sr,
    input logic             i_start,
    input logic [CW-1:0]    i_cnt,
    input logic [WIDTH-1:0] e_q,
    input logic             e_busy,
    input logic             e_done
  );
    exp_t e;
    rst   = i_rst;
    en    = i_en;
    mode  = i_mode;
    d     = i_d;
    sin_l = i_sl;
    sin_r = i_sr;
    start = i_start;
    cnt   = i_cnt;
    exp_q.push_back('{q: e_q, busy: e_busy, done: e_done});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (q === e.q) else begin
      errors++;
      $error("FAIL %s q observed=%h expected=%h", tag, q, e.q);
    end
    checks++;
    assert (busy === e.busy) else begin
      errors++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy, e.busy);
    end
    checks++;
    assert (done === e.done) else begin
      errors++;
      $error("FAIL %s done observed=%b expected=%b", tag, done, e.done);
    end
    checks++;
    assert ((sout_l === e.q[WIDTH-1]) && (sout_r === e.q[0])) else begin
      errors++;
      $error("FAIL %s sout observed=%b%b expected=%b%b", tag, sout_l, sout_r, e.q[WIDTH-1], e.q[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; mode = 3'b000; d = '0;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; cnt = '0;

    //    tag        rst  en   mode    d      sl   sr   st   cnt  exp_q  busy done
    // Reset then load, single ops
    step("rst0",     1,   1,   3'b001, 8'hA5, 0,   0,   0,   0,   8'h00, 0,   0);
    step("rst1",     1,   1,   3'b001, 8'hA5, 0,   0,   0,   0,   8'h00, 0,   0);
    step("load",     0,   1,   3'b001, 8'hA5, 0,   0,   0,   0,   8'hA5, 0,   0);
    step("shl",      0,   1,   3'b010, 8'h00, 0,   1,   0,   0,   8'h4B, 0,   0);
    step("rotr",     0,   1,   3'b101, 8'h00, 0,   0,   0,   0,   8'hA5, 0,   0);
    step("asr",      0,   1,   3'b110, 8'h00, 0,   0,   0,   0,   8'hD2, 0,   0);
    step("hold_en0", 0,   0,   3'b010, 8'h00, 0,   1,   0,   0,   8'hD2, 0,   0);

    // Rotl burst of 3, with ignored inputs while busy
    step("ld81",     0,   1,   3'b001, 8'h81, 0,   0,   0,   0,   8'h81, 0,   0);
    step("rotl_b1",  0,   0,   3'b100, 8'h00, 0,   0,   1,   3,   8'h03, 1,   0);
    step("rotl_b2",  0,   1,   3'b111, 8'hFF, 0,   0,   1,   5,   8'h06, 1,   0);
    step("rotl_b3",  0,   1,   3'b001, 8'hFF, 0,   0,   0,   0,   8'h0C, 0,   1);
    step("rotl_end", 0,   0,   3'b000, 8'h00, 0,   0,   0,   0,   8'h0C, 0,   0);

    // Zero-length burst, start with non-burst mode
    step("cnt0",     0,   1,   3'b010, 8'h00, 0,   1,   1,   0,   8'h0C, 0,   1);
    step("cnt0_end", 0,   0,   3'b000, 8'h00, 0,   0,   0,   0,   8'h0C, 0,   0);
    step("st_load",  0,   1,   3'b001, 8'h3C, 0,   0,   1,   3,   8'h3C, 0,   0);

    // cnt=9 saturates to 8 shl with sin_r=1
    step("sat1",     0,   0,   3'b010, 8'h00, 0,   1,   1,   9,   8'h79, 1,   0);
    step("sat2",     0,   0,   3'b000, 8'h00, 0,   1,   0,   0,   8'hF3, 1,   0);
    step("sat3",     0,   0,   3'b000, 8'h00, 0,   1,   0,   0,   8'hE7, 1,   0);
    step("sat4",     0,   0,   3'b000, 8'h00, 0,   1,   0,   0,   8'hCF, 1,   0);
    step("sat5",     0,   0,   3'b000, 8'h00, 0,   1,   0,   0,   8'h9F, 1,   0);
    step("sat6",     0,   0,   3'b000, 8'h00, 0,   1,   0,   0,   8'h3F, 1,   0);
    step("sat7",     0,   0,   3'b000, 8'h00, 0,   1,   0,   0,   8'h7F, 1,   0);
    step("sat8",     0,   0,   3'b000, 8'h00, 0,   1,   0,   0,   8'hFF, 0,   1);
    step("sat_end",  0,   0,   3'b000, 8'h00, 0,   1,   0,   0,   8'hFF, 0,   0);

    // Mid-burst reset on shr burst, then first op after reset
    step("clear",    0,   1,   3'b111, 8'h00, 0,   0,   0,   0,   8'h00, 0,   0);
    step("shr_b1",   0,   0,   3'b011, 8'h00, 1,   0,   1,   8,   8'h80, 1,   0);
    step("shr_b2",   0,   0,   3'b000, 8'h00, 1,   0,   0,   0,   8'hC0, 1,   0);
    step("shr_b3",   0,   0,   3'b000, 8'h00, 1,   0,   0,   0,   8'hE0, 1,   0);
    step("shr_rst",  1,   0,   3'b000, 8'h00, 1,   0,   0,   0,   8'h00, 0,   0);
    step("post_rst", 0,   0,   3'b000, 8'h00, 1,   0,   0,   0,   8'h00, 0,   0);
    step("ld01",     0,   1,   3'b001, 8'h01, 0,   0,   0,   0,   8'h01, 0,   0);

    // Back-to-back bursts, second start in the done cycle
    step("bb1_1",    0,   0,   3'b010, 8'h00, 0,   0,   1,   2,   8'h02, 1,   0);
    step("bb1_2",    0,   0,   3'b000, 8'h00, 0,   0,   0,   0,   8'h04, 0,   1);
    step("bb2_1",    0,   0,   3'b010, 8'h00, 0,   1,   1,   2,   8'h09, 1,   0);
    step("bb2_2",    0,   0,   3'b000, 8'h00, 0,   1,   0,   0,   8'h13, 0,   1);
    step("bb_end",   0,   0,   3'b000, 8'h00, 0,   0,   0,   0,   8'h13, 0,   0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_reg_n.md
SHIFT_REG_N -- requirements
Module: shift_reg_n

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits, legal range 2..64.
REQ-002 Parameter RST_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 Localparam CW = $clog2(WIDTH+1), width of the burst count.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  single-op enable; sampled only while idle.
REQ-007 mode  in  3  op select: 000 hold, 001 load, 010 shl, 011 shr, 100 rotl, 101 rotr, 110 asr, 111 clear.
REQ-008 d  in  WIDTH  parallel load data.
REQ-009 sin_l  in  1  serial-in bit entering at the MSB on shr.
REQ-010 sin_r  in  1  serial-in bit entering at the LSB on shl.
REQ-011 start  in  1  burst request: repeat the selected shift/rotate op cnt times.
REQ-012 cnt  in  CW  burst length, 0..WIDTH.
REQ-013 q  out  WIDTH  register contents.
REQ-014 sout_l  out  1  q[WIDTH-1], combinational from q.
REQ-015 sout_r  out  1  q[0], combinational from q.
REQ-016 busy  out  1  burst in progress.
REQ-017 done  out  1  one-cycle pulse on burst completion.

Function
REQ-018 The block SHALL use the states IDLE and BURST.
REQ-019 In IDLE with start=0 and en=1, the block SHALL apply mode once on the next edge.
REQ-020 In IDLE with start=0 and en=0, q SHALL hold.
REQ-021 Each op SHALL update q as follows:
- hold: q
- load: d
- shl: {q[W-2:0], sin_r}
- shr: {sin_l, q[W-1:1]}
- rotl: {q[W-2:0], q[W-1]}
- rotr: {q[0], q[W-1:1]}
- asr: {q[W-1], q[W-1:1]}
- clear: all zeros
REQ-022 In IDLE, start=1 with mode in 010..110 and cnt>0 SHALL take priority over en, latch mode and cnt, apply the op on that same edge, and enter BURST with remaining = cnt-1.
REQ-023 If remaining = 0 after that first edge (cnt=1), the block SHALL return to IDLE and pulse done in the next cycle without entering BURST.
REQ-024 start=1 with cnt=0 SHALL leave q unchanged and pulse done one cycle later.
REQ-025 start=1 with mode in 000, 001 or 111 SHALL be ignored, and en SHALL then govern as in REQ-019/020.
REQ-026 In BURST, the block SHALL apply the latched op each edge and decrement remaining.
REQ-027 The block SHALL leave BURST for IDLE on the edge where the final op is applied.
REQ-028 done SHALL be high for exactly the one cycle after the last op edge, while busy is already low.
REQ-029 busy SHALL be high exactly while in BURST.
REQ-030 A cnt-N burst SHALL occupy N edges of q change in total, with busy high for N-1 cycles.
REQ-031 In BURST, en, mode, cnt and start SHALL be ignored; a start arriving then SHALL be dropped, not queued.
REQ-032 sin_l and sin_r SHALL be sampled live on every burst edge, not latched.
REQ-033 cnt > WIDTH SHALL saturate to WIDTH.
REQ-034 A start in the same cycle as done SHALL be accepted, because the block is then idle.

Reset
REQ-035 rst=1 at an edge SHALL set q=RST_VAL, state=IDLE, busy=0, done=0 and remaining=0, overriding all other inputs.
REQ-036 rst asserted mid-burst SHALL abort the burst with no done pulse.
REQ-037 After rst deasserts, the first op SHALL be accepted on the first edge with rst=0.

Verification (WIDTH=8, RST_VAL=0)
REQ-038 Reset then load: rst=1 for 2 edges, then en=1, mode=001, d=8'hA5 -> q=8'h00 during reset, q=8'hA5 one edge after reset drops.
REQ-039 Single ops: from q=8'hA5, shl with sin_r=1 -> 8'h4B; then rotr -> 8'hA5; then asr -> 8'hD2.
REQ-040 Burst: from q=8'h81, start=1, mode=100, cnt=3 -> q=03, 06, 0C on successive edges; busy high 2 cycles; done pulses once after the last edge.
REQ-041 Edge cases:
- start with cnt=0 -> q unchanged, done pulses next cycle, busy stays 0.
- start with mode=001 and en=1 -> acts as a plain load.
- cnt=9 -> 8 shifts.
REQ-042 Mid-burst reset: shr burst cnt=8, sin_l=1, rst=1 on 4th edge -> q=8'h00, busy=0, no done pulse.
REQ-043 Back-to-back bursts: shl cnt=2 followed by start in the done cycle with cnt=2, sin_r=1, from 8'h01 -> q=04 after the first burst, 13 after the second.
